cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Parametrised, stateful Coprocessor-0 block for the refcpu core. It succeeds the stateless COP0 decoding: it holds the CP0 register file and serves MFC0 reads and MTC0 writes.
- It performs exception entry and ERET return with a registered PC redirect.
- It runs a prescaled Count/Compare timer and produces a masked interrupt request for the pipeline control FSM.

Parameters:
- HW_INT_NUM, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT_NUM-1:2]; unused IP bits read 0.
- COUNT_DIV, 2, core cycles per Count increment (>=1).
- RESET_BEV, 1, reset value of Status.BEV (bit 22).

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous active-low reset
- rd_addr  in  5  MFC0 register number
- rd_sel  in  3  MFC0 select
- rd_data  out  32  combinational read data
- wr_en  in  1  MTC0 write strobe
- wr_addr  in  5  MTC0 register number
- wr_sel  in  3  MTC0 select
- wr_data  in  32  MTC0 data
- eret  in  1  ERET commit strobe
- exc_valid  in  1  exception commit strobe
- exc_code  in  5  ExcCode for Cause[6:2]
- exc_pc  in  32  PC of the faulting instruction
- exc_in_ds  in  1  faulting instruction is in a delay slot
- exc_badvaddr_valid  in  1  update BadVAddr
- exc_badvaddr  in  32  faulting address
- hw_int  in  HW_INT_NUM  level-sensitive hardware interrupts
- int_req  out  1  an interrupt should be taken
- status_exl  out  1  current Status.EXL
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  32  redirect target

Behaviour:
- Implemented registers (sel 0 only; any other address or sel reads 0 and ignores writes):
  - BadVAddr(8): read-only.
  - Count(9): read/write.
  - Compare(11): read/write.
  - Status(12): writable bits 22 (BEV), 15:8 (IM), 1 (EXL), 0 (IE); other bits read 0.
  - Cause(13): writable bits 9:8 only; bit 31 BD, bit 30 TI, 15:10 hardware IP, 6:2 ExcCode.
  - EPC(14): read/write.
- Reset (resetn=0 at a clk edge) sets:
  - All registers 0, except Status.BEV=RESET_BEV.
  - Prescaler 0; redirect_valid=0; redirect_pc=0.
  - So int_req=0 and status_exl=0.
- rd_data is combinational from current register state. It does not bypass a same-cycle write.
- Timer:
  - The prescaler counts 0..COUNT_DIV-1. Count increments (mod 2^32) in the cycle the prescaler equals COUNT_DIV-1, and the prescaler wraps to 0.
  - A Count write loads wr_data, resets the prescaler to 0 and suppresses that cycle's increment.
  - When Count transitions to a value equal to Compare, TI is set in the following cycle.
  - TI stays set until a Compare write clears it. A Compare write wins over a same-cycle TI set.
- Interrupts:
  - Cause[10+k] is registered from hw_int[k] every cycle (one-cycle sample delay).
  - Cause[15] = hw_int[5] (if present) OR TI.
  - int_req = Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]), combinational from registers.
- Exception entry (exc_valid=1):
  - If EXL=0: EPC = exc_in_ds ? exc_pc-4 : exc_pc, and BD = exc_in_ds.
  - If EXL=1: EPC and BD are unchanged.
  - EXL is set to 1 and ExcCode = exc_code.
  - BadVAddr = exc_badvaddr if exc_badvaddr_valid.
  - Next cycle: redirect_valid=1, redirect_pc = BEV ? 32'hBFC0_0380 : 32'h8000_0180, using the BEV value before the update.
- ERET (eret=1, exc_valid=0):
  - EXL is cleared.
  - Next cycle: redirect_valid=1, redirect_pc = EPC value at the ERET cycle.
- Same-cycle priority: exc_valid > eret > wr_en.
  - A lower-priority event in a cycle with a higher-priority event is dropped entirely, including register side effects.
  - Timer counting and hw_int sampling always proceed.
- redirect_valid is high for exactly one cycle per accepted event. Back-to-back events produce back-to-back pulses.
- Reset asserted in the same cycle as any event: reset wins, and no redirect is issued.
- status_exl mirrors Status.EXL.

Test Plan:
1. Reset, then read Status (12), Cause (13) and register 7 -> rd_data = 32'h0040_0000, 0, 0. int_req=0, redirect_valid=0.
2. COUNT_DIV=2: write Count=5, idle 6 cycles -> Count reads 8. Write Compare=10 -> TI sets once Count reaches 10 and Cause bit30=1. With Status=32'h0000_8001, int_req=1 one cycle later. Writing Compare clears TI and drops int_req.
3. Exception with exc_pc=32'h8000_1004, exc_in_ds=1, exc_code=4, badvaddr=32'h1234_5679 -> EPC=32'h8000_1000, BD=1, ExcCode=4, BadVAddr=32'h1234_5679, EXL=1. Next cycle redirect_pc=32'hBFC0_0380, valid for one cycle.
4. Nested exception while EXL=1 with exc_pc=32'h8000_2000 -> EPC is unchanged. ERET next -> EXL=0 and redirect_pc=32'h8000_1000.
5. Same cycle exc_valid + eret + MTC0 EPC=32'hDEAD_BEEF -> only the exception takes effect. EPC ≠ 32'hDEAD_BEEF and EXL=1.
6. Status=32'h0000_0401, hw_int[0] raised -> Cause[10]=1 one cycle later and int_req=1. Set EXL via MTC0 -> int_req=0.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the refcpu core: CP0 register file, MFC0/MTC0 access,
// exception entry / ERET redirect, prescaled Count/Compare timer and interrupt request.
module cp0_unit #(
    parameter int   HW_INT_NUM = 6,
    parameter int   COUNT_DIV  = 2,
    parameter logic RESET_BEV  = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [4:0]            rd_addr,
    input  logic [2:0]            rd_sel,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [2:0]            wr_sel,
    input  logic [31:0]           wr_data,
    input  logic                  eret,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_in_ds,
    input  logic                  exc_badvaddr_valid,
    input  logic [31:0]           exc_badvaddr,
    input  logic [HW_INT_NUM-1:0] hw_int,
    output logic                  int_req,
    output logic                  status_exl,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc
);

    localparam int            PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    logic [31:0]           badvaddr_q, badvaddr_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic [31:0]           epc_q, epc_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic                  count_upd_q, count_upd_d;
    logic                  bev_q, bev_d;
    logic [7:0]            im_q, im_d;
    logic                  exl_q, exl_d;
    logic                  ie_q, ie_d;
    logic                  bd_q, bd_d;
    logic                  ti_q, ti_d;
    logic [HW_INT_NUM-1:0] hw_ip_q;
    logic [1:0]            sw_ip_q, sw_ip_d;
    logic [4:0]            exccode_q, exccode_d;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [31:0]           redirect_pc_q, redirect_pc_d;

    logic                  eret_s;
    logic                  wr_s;
    logic [5:0]            hw_ip_ext_s;
    logic [31:0]           status_rd_s;
    logic [31:0]           cause_rd_s;

    // Event acceptance: exception beats ERET beats MTC0; only sel 0 is implemented.
    assign eret_s = eret & ~exc_valid;
    assign wr_s   = wr_en & ~exc_valid & ~eret & (wr_sel == 3'd0);

    // Widen the sampled hardware lines to the full six IP positions.
    always_comb begin
        hw_ip_ext_s = 6'd0;
        for (int k = 0; k < HW_INT_NUM; k++) begin
            hw_ip_ext_s[k] = hw_ip_q[k];
        end
    end

    assign status_rd_s = {9'd0, bev_q, 6'd0, im_q, 6'd0, exl_q, ie_q};
    // IP7 is shared between the sixth hardware line and the timer.
    assign cause_rd_s  = {bd_q, ti_q, 14'd0, hw_ip_ext_s[5] | ti_q, hw_ip_ext_s[4:0],
                          sw_ip_q, 1'b0, exccode_q, 2'b00};

    // MFC0 read mux from current register state.
    always_comb begin
        rd_data = 32'd0;
        if (rd_sel == 3'd0) begin
            case (rd_addr)
                ADDR_BADVADDR: rd_data = badvaddr_q;
                ADDR_COUNT:    rd_data = count_q;
                ADDR_COMPARE:  rd_data = compare_q;
                ADDR_STATUS:   rd_data = status_rd_s;
                ADDR_CAUSE:    rd_data = cause_rd_s;
                ADDR_EPC:      rd_data = epc_q;
                default:       rd_data = 32'd0;
            endcase
        end else begin
            rd_data = 32'd0;
        end
    end

    // Timer next state: prescaled Count, Compare and the TI latch.
    always_comb begin
        presc_d     = presc_q;
        count_d     = count_q;
        count_upd_d = 1'b0;
        compare_d   = compare_q;
        ti_d        = ti_q;
        if (wr_s && (wr_addr == ADDR_COUNT)) begin
            count_d     = wr_data;
            presc_d     = {PW{1'b0}};
            count_upd_d = 1'b1;
        end else if (presc_q == PRESC_LAST) begin
            count_d     = count_q + 32'd1;
            presc_d     = {PW{1'b0}};
            count_upd_d = 1'b1;
        end else begin
            presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
        end
        // TI rises the cycle after Count lands on Compare; a Compare write wins.
        if (wr_s && (wr_addr == ADDR_COMPARE)) begin
            compare_d = wr_data;
            ti_d      = 1'b0;
        end else if (count_upd_q && (count_q == compare_q)) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end
    end

    // Exception, ERET and MTC0 effects on Status/Cause/EPC/BadVAddr and the redirect.
    always_comb begin
        badvaddr_d       = badvaddr_q;
        epc_d            = epc_q;
        bev_d            = bev_q;
        im_d             = im_q;
        exl_d            = exl_q;
        ie_d             = ie_q;
        bd_d             = bd_q;
        sw_ip_d          = sw_ip_q;
        exccode_d        = exccode_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (exc_valid) begin
            if (!exl_q) begin
                epc_d = exc_in_ds ? (exc_pc - 32'd4) : exc_pc;
                bd_d  = exc_in_ds;
            end else begin
                epc_d = epc_q;
                bd_d  = bd_q;
            end
            exl_d     = 1'b1;
            exccode_d = exc_code;
            if (exc_badvaddr_valid) begin
                badvaddr_d = exc_badvaddr;
            end else begin
                badvaddr_d = badvaddr_q;
            end
            redirect_valid_d = 1'b1;
            redirect_pc_d    = bev_q ? 32'hBFC0_0380 : 32'h8000_0180;
        end else if (eret_s) begin
            exl_d            = 1'b0;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = epc_q;
        end else if (wr_s) begin
            case (wr_addr)
                ADDR_STATUS: begin
                    bev_d = wr_data[22];
                    im_d  = wr_data[15:8];
                    exl_d = wr_data[1];
                    ie_d  = wr_data[0];
                end
                ADDR_CAUSE: sw_ip_d = wr_data[9:8];
                ADDR_EPC:   epc_d   = wr_data;
                default:    epc_d   = epc_q;
            endcase
        end else begin
            redirect_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            badvaddr_q       <= 32'd0;
            count_q          <= 32'd0;
            compare_q        <= 32'd0;
            epc_q            <= 32'd0;
            presc_q          <= {PW{1'b0}};
            count_upd_q      <= 1'b0;
            bev_q            <= RESET_BEV;
            im_q             <= 8'd0;
            exl_q            <= 1'b0;
            ie_q             <= 1'b0;
            bd_q             <= 1'b0;
            ti_q             <= 1'b0;
            hw_ip_q          <= {HW_INT_NUM{1'b0}};
            sw_ip_q          <= 2'd0;
            exccode_q        <= 5'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            badvaddr_q       <= badvaddr_d;
            count_q          <= count_d;
            compare_q        <= compare_d;
            epc_q            <= epc_d;
            presc_q          <= presc_d;
            count_upd_q      <= count_upd_d;
            bev_q            <= bev_d;
            im_q             <= im_d;
            exl_q            <= exl_d;
            ie_q             <= ie_d;
            bd_q             <= bd_d;
            ti_q             <= ti_d;
            hw_ip_q          <= hw_int;
            sw_ip_q          <= sw_ip_d;
            exccode_q        <= exccode_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign int_req        = ie_q & ~exl_q & (|(cause_rd_s[15:8] & im_q));
    assign status_exl     = exl_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit (HW_INT_NUM=6, COUNT_DIV=2, RESET_BEV=1).
module tb_cp0_unit;

    logic        clk;
    logic        resetn;
    logic [4:0]  rd_addr;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [2:0]  wr_sel;
    logic [31:0] wr_data;
    logic        eret;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_ds;
    logic        exc_badvaddr_valid;
    logic [31:0] exc_badvaddr;
    logic [5:0]  hw_int;
    logic        int_req;
    logic        status_exl;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_vec  = 0;
    int n_miss = 0;

    cp0_unit #(.HW_INT_NUM(6), .COUNT_DIV(2), .RESET_BEV(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data),
        .eret(eret), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_in_ds(exc_in_ds), .exc_badvaddr_valid(exc_badvaddr_valid),
        .exc_badvaddr(exc_badvaddr), .hw_int(hw_int), .int_req(int_req),
        .status_exl(status_exl), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        rd_addr = a;
        rd_sel  = 3'd0;
        #1;
        v = rd_data;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_sel  = 3'd0;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        bit          seen;
        resetn = 1'b0; rd_addr = 5'd0; rd_sel = 3'd0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_sel = 3'd0; wr_data = 32'd0;
        eret = 1'b0; exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0;
        exc_in_ds = 1'b0; exc_badvaddr_valid = 1'b0; exc_badvaddr = 32'd0; hw_int = 6'd0;
        tick();
        tick();
        resetn = 1'b1;

        // Reset state
        rd(5'd12, v); check("rst_status", v, 32'h0040_0000);
        rd(5'd13, v); check("rst_cause", v, 32'd0);
        rd(5'd7, v);  check("rst_reg7", v, 32'd0);
        check("rst_int_req", {31'd0, int_req}, 32'd0);
        check("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        check("rst_exl", {31'd0, status_exl}, 32'd0);

        // Timer: Count=5 then 6 idle cycles at two cycles per tick -> 8
        mtc0(5'd9, 32'd5);
        for (int i = 0; i < 6; i++) tick();
        rd(5'd9, v); check("count_8", v, 32'd8);
        mtc0(5'd12, 32'h0040_8001);
        mtc0(5'd11, 32'd10);
        check("int_req_pre_ti", {31'd0, int_req}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            rd(5'd13, v);
            if (v[30]) seen = 1'b1;
            else tick();
        end
        check("ti_set", {31'd0, seen}, 32'd1);
        rd(5'd9, v); check("count_at_ti", v, 32'd10);
        check("int_req_ti", {31'd0, int_req}, 32'd1);
        mtc0(5'd11, 32'hFFFF_0000);
        rd(5'd13, v); check("ti_cleared", {31'd0, v[30]}, 32'd0);
        check("int_req_cleared", {31'd0, int_req}, 32'd0);

        // Exception in a delay slot with BEV=1
        exc_valid = 1'b1; exc_pc = 32'h8000_1004; exc_in_ds = 1'b1; exc_code = 5'd4;
        exc_badvaddr_valid = 1'b1; exc_badvaddr = 32'h1234_5679;
        tick();
        exc_valid = 1'b0; exc_badvaddr_valid = 1'b0; exc_in_ds = 1'b0;
        check("exc_redir_v", {31'd0, redirect_valid}, 32'd1);
        check("exc_redir_pc", redirect_pc, 32'hBFC0_0380);
        check("exc_exl", {31'd0, status_exl}, 32'd1);
        rd(5'd14, v); check("exc_epc", v, 32'h8000_1000);
        rd(5'd13, v); check("exc_cause", v, 32'h8000_0010);
        rd(5'd8, v);  check("exc_badvaddr", v, 32'h1234_5679);
        tick();
        check("exc_redir_one", {31'd0, redirect_valid}, 32'd0);

        // Nested exception keeps EPC/BD, then back-to-back ERET
        exc_valid = 1'b1; exc_pc = 32'h8000_2000; exc_code = 5'd5;
        tick();
        exc_valid = 1'b0;
        rd(5'd14, v); check("nest_epc", v, 32'h8000_1000);
        rd(5'd13, v); check("nest_cause", v, 32'h8000_0014);
        rd(5'd8, v);  check("nest_badvaddr", v, 32'h1234_5679);
        check("nest_redir_v", {31'd0, redirect_valid}, 32'd1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("eret_redir_v", {31'd0, redirect_valid}, 32'd1);
        check("eret_redir_pc", redirect_pc, 32'h8000_1000);
        check("eret_exl", {31'd0, status_exl}, 32'd0);

        // Exception + ERET + MTC0 EPC in one cycle: only the exception lands
        exc_valid = 1'b1; eret = 1'b1; exc_pc = 32'h8000_3000; exc_code = 5'd8;
        wr_en = 1'b1; wr_addr = 5'd14; wr_sel = 3'd0; wr_data = 32'hDEAD_BEEF;
        tick();
        exc_valid = 1'b0; eret = 1'b0; wr_en = 1'b0;
        rd(5'd14, v); check("prio_epc", v, 32'h8000_3000);
        check("prio_exl", {31'd0, status_exl}, 32'd1);
        check("prio_redir_pc", redirect_pc, 32'hBFC0_0380);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("eret2_redir_pc", redirect_pc, 32'h8000_3000);

        // Hardware interrupt 0 through IM2
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        #1;
        check("hw_int_delay", {31'd0, int_req}, 32'd0);
        tick();
        rd(5'd13, v); check("cause_ip2", {31'd0, v[10]}, 32'd1);
        check("hw_int_req", {31'd0, int_req}, 32'd1);
        mtc0(5'd12, 32'h0000_0403);
        check("exl_masks_int", {31'd0, int_req}, 32'd0);
        check("exl_by_mtc0", {31'd0, status_exl}, 32'd1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        exc_valid = 1'b1; exc_pc = 32'h8000_4000;
        tick();
        exc_valid = 1'b0;
        check("bev0_vector", redirect_pc, 32'h8000_0180);

        // Reset in the same cycle as an exception
        hw_int = 6'd0;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        exc_valid = 1'b1; resetn = 1'b0;
        tick();
        exc_valid = 1'b0; resetn = 1'b1;
        check("rst_evt_redir", {31'd0, redirect_valid}, 32'd0);
        check("rst_evt_exl", {31'd0, status_exl}, 32'd0);
        rd(5'd12, v); check("rst_evt_status", v, 32'h0040_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
